// File: rtl/sram_sdp_be_if.sv
// rtl/sram_sdp_be_if.sv - write/read port bundle for sram_sdp_be
//
// Purpose: groups the write port, read port and ready status of sram_sdp_be.
// Signals:
//   ready  - clear sweep done, requests accepted
//   we/be/waddr/wdata - write request, byte-lane enables, address, data
//   re/raddr          - read request and address
//   rdata/rvalid      - registered read data and its one-cycle strobe
// Modports: master drives requests, slave (the memory) drives responses.
interface sram_sdp_be_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    localparam int BE_W = DATA_W / 8;

    logic              ready;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        input  ready, rdata, rvalid,
        output we, be, waddr, wdata, re, raddr
    );

    modport slave (
        output ready, rdata, rvalid,
        input  we, be, waddr, wdata, re, raddr
    );
endinterface

// File: rtl/sram_sdp_be.sv
// rtl/sram_sdp_be.sv - simple-dual-port SRAM with byte enables and post-reset clear sweep
//
// Purpose: one write port and one read port per cycle, per-byte write enables,
// registered read data with an rvalid strobe. After reset every word is swept
// to zero (DEPTH cycles) before ready rises; requests are ignored until then.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - sram_sdp_be_if.slave (ready, we, be, waddr, wdata, re, raddr, rdata, rvalid)
// Option: SRAM_WRITE_FIRST_EN selects write-first behaviour for a same-address
// read/write in one cycle; default is read-first (old contents returned).
module sram_sdp_be #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_sdp_be_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    logic              ready;
    logic              clear_wr;
    logic              run_wr;
    logic              run_rd;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_word;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the sweep ends on the edge that clears the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = S_RUN;
            end
        end
    end

    // Outputs / datapath controls
    always_comb begin
        ready    = (state_q == S_RUN);
        clear_wr = rst_n && (state_q == S_CLEAR);
        run_wr   = rst_n && ready && bus.we;
        run_rd   = rst_n && ready && bus.re;
    end

    // Word as it will look after this cycle's write: enabled lanes from wdata
    always_comb begin
        wr_merged = mem[bus.waddr];
        for (int i = 0; i < BE_W; i++) begin
            if (bus.be[i]) begin
                wr_merged[i*8 +: 8] = bus.wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[bus.raddr];
`ifdef SRAM_WRITE_FIRST_EN
        if (run_wr && (bus.waddr == bus.raddr)) begin
            rd_word = wr_merged;
        end
`endif
    end

    // Storage has no reset; contents are defined by the clear sweep
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem[cnt_q] <= '0;
        end else if (run_wr) begin
            mem[bus.waddr] <= wr_merged;
        end
    end

    // rdata only changes on an accepted read, so it holds between reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= run_rd;
            if (run_rd) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign bus.ready  = ready;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_sram_sdp_be.sv
// tb/tb_sram_sdp_be.sv - self-checking bench for sram_sdp_be
module tb_sram_sdp_be;
`ifdef SRAM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_sdp_be_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    sram_sdp_be #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_mem [16];
    int          clear_left = 0;
    logic        exp_ready  = 1'b0;
    logic        exp_rvalid = 1'b0;
    logic [15:0] exp_rdata  = 16'h0000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference model for this edge, check after the edge
    task automatic step(input logic rst, input logic we, input logic [1:0] be,
                        input logic [3:0] wa, input logic [15:0] wd,
                        input logic re, input logic [3:0] ra);
        logic [15:0] merged;
        logic [15:0] old;
        rst_n      = rst;
        bus.we     = we;
        bus.be     = be;
        bus.waddr  = wa;
        bus.wdata  = wd;
        bus.re     = re;
        bus.raddr  = ra;
        @(posedge clk);
        if (!rst) begin
            // After the sweep every word is zero; reads are impossible meanwhile
            for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
            clear_left = 16;
            exp_ready  = 1'b0;
            exp_rvalid = 1'b0;
            exp_rdata  = 16'h0000;
        end else if (clear_left > 0) begin
            clear_left--;
            exp_rvalid = 1'b0;
            exp_ready  = (clear_left == 0);
        end else begin
            old    = ref_mem[ra];
            merged = ref_mem[wa];
            for (int i = 0; i < 2; i++)
                if (be[i]) merged[i*8 +: 8] = wd[i*8 +: 8];
            exp_rvalid = re;
            if (re) exp_rdata = (WF && we && wa == ra) ? merged : old;
            if (we) ref_mem[wa] = merged;
        end
        #1;
        chk("ready",  {15'b0, bus.ready},  {15'b0, exp_ready});
        chk("rvalid", {15'b0, bus.rvalid}, {15'b0, exp_rvalid});
        chk("rdata",  bus.rdata, exp_rdata);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
        step(1'b1, 1'b1, be, a, d, 1'b0, 4'h0);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
        step(1'b1, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, a);
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        logic [15:0] coll_exp;

        // Reset 2 cycles, then sweep with requests pending that must be ignored
        step(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        step(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        chk("rst_ready", {15'b0, bus.ready}, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 2'b11, 4'h1, 16'hbeef, 1'b1, 4'h1);
            if (i == 14) chk("ready_low_15", {15'b0, bus.ready}, 16'h0000);
        end
        chk("ready_after_16", {15'b0, bus.ready}, 16'h0001);
        chk("rvalid_in_clear", {15'b0, bus.rvalid}, 16'h0000);
        for (int a = 0; a < 16; a++) rd("clear_rd", 4'(a), 16'h0000);
        rd("rd1_after_clear", 4'h1, 16'h0000);
        idle();
        chk("rvalid_drop", {15'b0, bus.rvalid}, 16'h0000);

        // Full-word writes
        wr(4'h0, 2'b11, 16'haaaa);
        wr(4'h2, 2'b11, 16'h5678);
        wr(4'h4, 2'b11, 16'hb4b3);
        wr(4'h6, 2'b11, 16'hcccc);
        rd("rd0", 4'h0, 16'haaaa);
        rd("rd2", 4'h2, 16'h5678);
        rd("rd4", 4'h4, 16'hb4b3);
        rd("rd6", 4'h6, 16'hcccc);
        rd("rd1", 4'h1, 16'h0000);
        rd("rd5", 4'h5, 16'h0000);
        idle();
        chk("rdata_hold", bus.rdata, 16'h0000);

        // Byte enables
        wr(4'h3, 2'b11, 16'h1234);
        wr(4'h3, 2'b01, 16'hffff);
        rd("be_lo", 4'h3, 16'h12ff);
        wr(4'h3, 2'b00, 16'h0000);
        rd("be_none", 4'h3, 16'h12ff);

        // Same-address collision
        wr(4'h7, 2'b11, 16'h00aa);
        step(1'b1, 1'b1, 2'b10, 4'h7, 16'h5500, 1'b1, 4'h7);
        coll_exp = WF ? 16'h55aa : 16'h00aa;
        chk("collide", bus.rdata, coll_exp);
        rd("collide_after", 4'h7, 16'h55aa);

        // Different addresses same cycle are independent
        step(1'b1, 1'b1, 2'b11, 4'h9, 16'h1357, 1'b1, 4'h0);
        chk("indep_rd", bus.rdata, 16'haaaa);
        rd("indep_wr", 4'h9, 16'h1357);

        // Reset mid-operation with a read pending
        wr(4'h2, 2'b11, 16'h5678);
        step(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h2);
        chk("midrst_rvalid", {15'b0, bus.rvalid}, 16'h0000);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h2);
        chk("midrst_ready", {15'b0, bus.ready}, 16'h0001);
        rd("midrst_rd2", 4'h2, 16'h0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 199) != 0),
                 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
                 1'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_sdp_be.md
# sram_sdp_be

Parametrised simple-dual-port synchronous SRAM with per-byte write enables, registered read data with a valid strobe, and an automatic zero-clear sweep after reset. It replaces the fixed 16x16 single-port data memory as the general on-chip buffer/data store and serves one writer and one reader per cycle.

## Interface
- DATA_W, 16, data width in bits; must be a multiple of 8
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- BE_W, DATA_W/8, byte-enable width (derived; do not override)

- clk  input  1  rising-edge clock; all state updates on this edge
- rst_n  input  1  synchronous, active-low reset
- ready  output  1  1 = clear sweep done, ports accept requests
- we  input  1  write request
- be  input  BE_W  byte-lane enables for the write; be[i] covers wdata[8i+7:8i]
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- re  input  1  read request
- raddr  input  ADDR_W  read address
- rdata  output  DATA_W  registered read data
- rvalid  output  1  1 for exactly one cycle per accepted read

## Operation
- FSM states: CLEAR, RUN.
- rst_n low at a clock edge: state <= CLEAR, clear counter <= 0, ready <= 0, rdata <= 0, rvalid <= 0. Applies mid-operation too; any in-flight read is dropped (no rvalid).
- CLEAR: each cycle writes all-zero to mem[counter], counter increments; on the edge writing DEPTH-1 state <= RUN, ready <= 1. we/re ignored while ready = 0 (no write, rvalid stays 0).
- RUN, write: we = 1 at an edge updates only lanes with be[i] = 1; other lanes keep old contents. we = 1 with be = 0 is a no-op.
- RUN, read: re = 1 at edge N -> rdata = mem[raddr] and rvalid = 1 after edge N; rvalid = 0 after any edge with re = 0.
- rdata holds its last value when no read is accepted; it is never cleared except by reset.
- Address wrap: addresses are exactly ADDR_W bits, no out-of-range case; counter wraps are not used (sweep ends at DEPTH-1).
- Read and write to different addresses in the same cycle: fully independent.
- Same address, same cycle: governed by SRAM_WRITE_FIRST_EN (see Configuration).

## Timing
- Reset to ready: rst_n released before edge 0; CLEAR writes on edges 0..DEPTH-1; ready = 1 after edge DEPTH-1 (DEPTH cycles, 16 for defaults).
- Write latency: data visible to a read issued on the next edge.
- Read latency: 1 cycle, registered; back-to-back reads every cycle give rvalid continuously high.
- No backpressure: every request in RUN is accepted in the cycle presented.

## Configuration
- SRAM_WRITE_FIRST_EN defined: same-address same-cycle read returns the merged result: enabled lanes from wdata, disabled lanes from old mem contents.
- Undefined (default): read-first; rdata returns the old mem contents for all lanes, the write still completes.

## Test plan
- Reset then wait: rst_n low 2 cycles, release -> ready = 0 for 16 cycles, then 1; reads of addresses 0..15 all return 16'h0000 with rvalid pulses.
- Full-word writes: be = 2'b11, write 0 <- 16'haaaa, 2 <- 16'h5678, 4 <- 16'hb4b3, 6 <- 16'hcccc; read 0,2,4,6,1,5 -> aaaa, 5678, b4b3, cccc, 0000, 0000, each one cycle after re.
- Byte enables: mem[3] = 16'h1234, write 3 <- 16'hffff with be = 2'b01 -> read 3 = 16'h12ff; then be = 2'b00 with 16'h0000 -> still 12ff.
- Same-address collision: mem[7] = 16'h00aa, same cycle we = 1, be = 2'b10, wdata = 16'h5500, re = 1, raddr = waddr = 7 -> rdata = 16'h55aa with SRAM_WRITE_FIRST_EN, 16'h00aa without; next read of 7 = 16'h55aa in both builds.
- Requests during CLEAR: drive we = 1 (addr 1, 16'hbeef) and re = 1 during the sweep -> rvalid stays 0; after ready, read 1 = 16'h0000.
- Reset mid-operation: write 16'h5678 to 2, assert rst_n low for 1 cycle with re = 1 pending -> no rvalid, ready drops for 16 cycles, read 2 afterwards = 16'h0000.
